digit_serialiser: RTL

Parametrised successor to the single-bit data serialiser, sitting between the word-wide block RAM and the bit-serial datapath. It moves DIGIT_W bits per cycle instead of one. It handles RISC-V load/store sizing in hardware: byte-lane placement, write mask, sign/zero extension and misalignment detection. On loads it unpacks a memory word into an LSB-first digit stream. On stores it gathers a digit stream into a lane-aligned word plus byte write mask.

---
 rtl/digit_serialiser.sv | 102 ++++++++++
 1 files changed

// File: rtl/digit_serialiser.sv
// digit_serialiser: RISC-V sized load unpack / store gather between word RAM and a digit-serial datapath
module digit_serialiser #(
    parameter int WORD_W  = 32,
    parameter int DIGIT_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [2:0]            func,
    input  logic [1:0]            byte_off,
    input  logic [WORD_W-1:0]     word_in,
    input  logic [DIGIT_W-1:0]    digit_in,
    output logic [DIGIT_W-1:0]    digit_out,
    output logic                  digit_valid,
    output logic                  digit_ready,
    output logic [WORD_W-1:0]     word_out,
    output logic [WORD_W/8-1:0]   wr_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned
);
    localparam int N  = WORD_W / DIGIT_W;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam int MW = WORD_W / 8;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] shreg, shifted, val_mask, extracted, gathered;
    logic [MW-1:0]     bmask;
    logic [2:0]        func_q, fsel;
    logic [1:0]        off_q, osel, lg;
    logic [5:0]        sbits;
    logic              mis_q, bad, last, sign, is_b, is_h, is_w;

    // Sizing is decoded from the live inputs in IDLE and from the latched copy afterwards
    always_comb begin
        fsel      = state == IDLE ? func : func_q;
        osel      = state == IDLE ? byte_off : off_q;
        is_b      = fsel[1:0] == 2'b00;
        is_h      = fsel[1:0] == 2'b01;
        is_w      = fsel[1];
        lg        = is_b ? 2'd0 : is_h ? 2'd1 : 2'd2;
        sbits     = 6'd8 << lg;
        val_mask  = ~({WORD_W{1'b1}} << sbits);
        bmask     = ~({MW{1'b1}} << (3'd1 << lg));
        bad       = (is_h & osel[0]) | (is_w & (osel != 2'd0));
        shifted   = word_in >> {osel, 3'b000};
        sign      = ~fsel[2] & ~is_w & (is_b ? shifted[7] : shifted[15]);
        extracted = (shifted & val_mask) | (sign ? ~val_mask : '0);
        gathered  = (shreg >> DIGIT_W) | (WORD_W'(digit_in) << (WORD_W - DIGIT_W));
        last      = cnt == LAST;
        state_nx  = state == IDLE ? (start ? (bad ? DONE : mode ? STORE : LOAD) : IDLE)
                  : state == DONE ? IDLE
                  : last ? DONE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            shreg    <= '0;
            func_q   <= '0;
            off_q    <= '0;
            mis_q    <= 1'b0;
            word_out <= '0;
            wr_mask  <= '0;
        end else if (state == IDLE && start) begin
            cnt      <= '0;
            shreg    <= mode ? '0 : extracted;
            func_q   <= func;
            off_q    <= byte_off;
            mis_q    <= bad;
            word_out <= '0;
            wr_mask  <= '0;
        end else if (state == LOAD) begin
            shreg <= shreg >> DIGIT_W;
            cnt   <= cnt + 1'b1;
        end else if (state == STORE) begin
            shreg <= gathered;
            cnt   <= cnt + 1'b1;
            if (last) begin
                word_out <= (gathered & val_mask) << {off_q, 3'b000};
                wr_mask  <= bmask << off_q;
            end
        end
    end

    assign digit_out   = state == LOAD ? shreg[DIGIT_W-1:0] : '0;
    assign digit_valid = state == LOAD;
    assign digit_ready = state == STORE;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign misaligned  = done & mis_q;
endmodule
